// File: rtl/pipe_reg_elastic.sv
// Elastic valid/ready register chain: STAGES deep, with bubble collapsing, global stall (en) and flush.
// Define PIPE_REG_OCC_EN to add the registered occupancy output.
module pipe_reg_elastic #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           STAGES     = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
`ifdef PIPE_REG_OCC_EN
  , output logic [$clog2(STAGES+1)-1:0] occupancy
`endif
);

  logic [STAGES-1:0]     v;
  logic [DATA_WIDTH-1:0] d     [STAGES];
  logic [STAGES-1:0]     r;
  logic [STAGES-1:0]     src_v;
  logic [DATA_WIDTH-1:0] src_d [STAGES];

  // Stage i can take a word when the chain runs and it is empty or its successor moves.
  always_comb begin : ready_chain
    logic acc;
    acc = out_ready;
    r   = '0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      acc  = en && (!v[i] || acc);
      r[i] = acc;
    end
  end

  always_comb begin : stage_sources
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int i = 1; i < int'(STAGES); i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  // Neither a flush nor a reset cycle may swallow an upstream word.
  assign in_ready  = r[0] && !flush && !rst;
  assign out_valid = en && v[STAGES-1];
  assign out_data  = d[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < int'(STAGES); i++) d[i] <= RESET_VAL;
    end else if (flush) begin
      v <= '0;
    end else if (en) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        if (r[i]) begin
          v[i] <= src_v[i];
          if (src_v[i]) d[i] <= src_d[i];
        end
      end
    end
  end

`ifdef PIPE_REG_OCC_EN
  localparam int unsigned OCC_W = $clog2(STAGES + 1);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Tracks popcount(v) without an adder tree.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed bench for pipe_reg_elastic with a scoreboard queue of expected output words.
module tb_pipe_reg_elastic;
  localparam int unsigned DW     = 8;
  localparam int          STAGES = 3;
  localparam logic [7:0]  RV     = 8'hA5;

  logic          clk;
  logic          rst;
  logic          en;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
`ifdef PIPE_REG_OCC_EN
  logic [$clog2(STAGES+1)-1:0] occupancy;
`endif

  pipe_reg_elastic #(
    .DATA_WIDTH(DW),
    .STAGES    (STAGES),
    .RESET_VAL (RV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
`ifdef PIPE_REG_OCC_EN
    , .occupancy(occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int n_in = 0;
  int n_out = 0;
  int acc_cyc = -1;
  int out_cyc = -1;
  int last_out_cyc = -1;
  bit started = 1'b0;
  bit accepted = 1'b0;
  logic [DW-1:0] q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample just after the falling edge, score transfers, advance to next falling edge.
  task automatic tick();
    logic          exp_rdy;
    logic [DW-1:0] e;
    #1;
    cyc_n++;
    accepted = 1'b0;
    exp_rdy = en && !flush && !rst && (out_ready || (q.size() < STAGES));
    if (started) check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (!en) check("out_valid_stall", 32'(out_valid), 32'(0));
`ifdef PIPE_REG_OCC_EN
    if (started && !rst) check("occupancy", 32'(occupancy), 32'(q.size()));
`endif
    if (in_valid && in_ready && !rst) begin
      q.push_back(in_data);
      n_in++;
      accepted = 1'b1;
      if (acc_cyc < 0) acc_cyc = cyc_n;
    end
    if (started && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("sb_underflow", 32'(1), 32'(0));
      end else begin
        e = q.pop_front();
        check("sb_data", 32'(out_data), 32'(e));
      end
      n_out++;
      if (out_cyc < 0) out_cyc = cyc_n;
      last_out_cyc = cyc_n;
    end
    if (rst || flush) q.delete();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (accepted) break;
    end
    if (!accepted) check("push_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < max_cyc; k++) begin
      if (q.size() == 0) break;
      tick();
    end
    check("drain_empty", 32'(q.size()), 32'(0));
    tick();
  endtask

  initial begin : stim
    int in0;
    int out0;
    rst = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);

    // 1: reset state
    tick();
    started = 1'b1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(RV));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    tick();

    // 2: streaming at full rate, latency and throughput
    out_ready = 1'b1;
    acc_cyc = -1; out_cyc = -1;
    out0 = n_out;
    for (int w = 1; w <= 10; w++) push_word(8'(w));
    drain(20);
    check("stream_latency", 32'(out_cyc - acc_cyc), 32'(STAGES));
    check("stream_count", 32'(n_out - out0), 32'(10));
    check("stream_back_to_back", 32'(last_out_cyc - out_cyc), 32'(9));

    // 3: back-pressure fills the chain, then drains in order
    out_ready = 1'b0;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    in_valid = 1'b1; in_data = 8'h44;
    #1;
    check("full_in_ready", 32'(in_ready), 32'(0));
    check("full_out_valid", 32'(out_valid), 32'(1));
`ifdef PIPE_REG_OCC_EN
    check("full_occupancy", 32'(occupancy), 32'(3));
`endif
    tick();
    out_ready = 1'b1;
    push_word(8'h44);
    drain(10);

    // 4: flush while full
    out_ready = 1'b0;
    push_word(8'hA1);
    push_word(8'hA2);
    push_word(8'hA3);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'(0));
    check("flush_head_valid", 32'(out_valid), 32'(1));
    check("flush_head_data", 32'(out_data), 32'(8'hA1));
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("post_flush_valid", 32'(out_valid), 32'(0));
`ifdef PIPE_REG_OCC_EN
    check("post_flush_occ", 32'(occupancy), 32'(0));
`endif
    repeat (3) tick();

    // 5: mid-stream stall
    in0 = n_in; out0 = n_out;
    out_ready = 1'b1;
    push_word(8'h31);
    push_word(8'h32);
    push_word(8'h33);
    en = 1'b0; in_valid = 1'b1; in_data = 8'h34;
    repeat (4) begin
      #1;
      check("stall_in_ready", 32'(in_ready), 32'(0));
      tick();
    end
    en = 1'b1;
    push_word(8'h34);
    push_word(8'h35);
    push_word(8'h36);
    drain(10);
    check("stall_in_count", 32'(n_in - in0), 32'(6));
    check("stall_out_count", 32'(n_out - out0), 32'(6));

    // 6: reset together with flush while full, then a single word
    out_ready = 1'b0;
    push_word(8'hB1);
    push_word(8'hB2);
    push_word(8'hB3);
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    #1;
    check("rst2_out_valid", 32'(out_valid), 32'(0));
    check("rst2_out_data", 32'(out_data), 32'(RV));
    check("rst2_in_ready", 32'(in_ready), 32'(1));
`ifdef PIPE_REG_OCC_EN
    check("rst2_occ", 32'(occupancy), 32'(0));
`endif
    tick();
    out_ready = 1'b1;
    acc_cyc = -1; out_cyc = -1;
    out0 = n_out;
    push_word(8'h77);
    drain(10);
    check("single_latency", 32'(out_cyc - acc_cyc), 32'(STAGES));
    check("single_count", 32'(n_out - out0), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
